// File: rtl/kernel_seq_pkg.sv
// Shared encodings for the kernel-launch sequencer and its token counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kernel_seq_pkg;

  // Sequencer states; the encodings are fixed so they read directly in waveforms.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The "no kernel" ID. It is wide enough for any ID width up to 64 bits,
  // and users slice it down to their own width.
  localparam logic [63:0] KID_IDLE = '0;

endpackage

// File: rtl/kernel_id_sequencer_token_counter.sv
// Output-token counter: it clears, increments on each handshake, and saturates at all-ones.
// Latency: the count updates one cycle after the increment; o_term is combinational on the same cycle.
// Backpressure: none; it only observes handshakes qualified by the parent.
module token_counter #(
  parameter int SIZECNT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_inc,
  input  logic [SIZECNT-1:0] i_len,
  output logic [SIZECNT-1:0] o_cnt,
  output logic               o_term
);

  localparam logic [SIZECNT-1:0] CNT_MAX = '1;
  localparam logic [SIZECNT-1:0] CNT_ONE = SIZECNT'(1);

  logic [SIZECNT-1:0] r_cnt;
  logic [SIZECNT-1:0] w_len_m1;

  // This handshake is the last token when the count already equals len-1.
  assign w_len_m1 = i_len - CNT_ONE;
  assign o_term   = i_inc && (r_cnt == w_len_m1);
  assign o_cnt    = r_cnt;

  // The count clears on a new launch and otherwise counts up, holding at the maximum value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/kernel_id_sequencer.sv
// Launches one kernel at a time: kernelID is held non-zero for the whole computation and done pulses at the end.
// Latency: kernelID is visible 1 cycle after accept; done comes 1 cycle after the final token or abort; next accept is at completion+2.
// Backpressure: cfg_ready is high only in IDLE. Output tokens are only monitored and never stalled.
module kernel_id_sequencer
  import kernel_seq_pkg::*;
#(
  parameter int SIZEID  = 8,
  parameter int SIZECNT = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [SIZEID-1:0]  cfg_id,
  input  logic [SIZECNT-1:0] cfg_len,
  input  logic               abort,
  input  logic               out_valid,
  input  logic               out_ready,
  output logic [SIZEID-1:0]  kernelID,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SIZECNT-1:0] tok_cnt
);

  localparam logic [SIZEID-1:0] W_KID_IDLE = KID_IDLE[SIZEID-1:0];

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_err_nxt;

  logic [SIZEID-1:0]  r_id;
  logic [SIZECNT-1:0] r_len;

  logic [SIZEID-1:0]  r_kernel_id;
  logic               r_cfg_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_tok_hs;
  logic               w_term;
  logic [SIZEID-1:0]  w_id_nxt;

  // r_cfg_ready is high only while in IDLE, so it qualifies the accept on its own.
  assign w_accept = cfg_valid && r_cfg_ready;
  // Tokens count only while a computation runs. Traffic in IDLE and DONE is ignored.
  assign w_tok_hs = out_valid && out_ready && (r_state == ST_RUN);
  assign w_id_nxt = w_accept ? cfg_id : r_id;

  token_counter #(
    .SIZECNT (SIZECNT)
  ) u_token_counter (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_clr   (w_accept),
    .i_inc   (w_tok_hs),
    .i_len   (r_len),
    .o_cnt   (tok_cnt),
    .o_term  (w_term)
  );

  // Next-state logic. Abort takes priority over a final token in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cfg_id == W_KID_IDLE) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = 1'b1;
          end else if (cfg_len == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
        end else if (w_term) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the command on accept. Command changes during RUN are ignored.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id  <= '0;
      r_len <= '0;
    end else if (w_accept) begin
      r_id  <= cfg_id;
      r_len <= cfg_len;
    end
  end

  // Outputs are registered from the next state, so each one changes with the state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_kernel_id <= W_KID_IDLE;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_kernel_id <= (w_state_nxt == ST_RUN) ? w_id_nxt : W_KID_IDLE;
      r_cfg_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_err       <= (w_state_nxt == ST_DONE) && w_err_nxt;
    end
  end

  assign kernelID  = r_kernel_id;
  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_kernel_id_sequencer.sv
// Bench for kernel_id_sequencer: directed launch/abort/reset cases, then random commands against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_kernel_id_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_id;
  logic [15:0] cfg_len;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  kernelID;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] tok_cnt;

  int total;
  int bad;

  kernel_id_sequencer #(
    .SIZEID  (8),
    .SIZECNT (16)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_id    (cfg_id),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .kernelID  (kernelID),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .tok_cnt   (tok_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Hard stop in case something wedges the bench itself.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one command from IDLE. The model only counts handshakes and decides
  // how the command ends: by abort, by reaching len tokens, or at once (id 0 / len 0).
  task automatic run_cmd(input logic [7:0] id, input logic [15:0] len, input int hs_pct,
                         input int abort_pct, input int abort_at, input int stall);
    int cnt;
    int cyc;
    bit fin;
    bit exp_err;
    bit hs;
    bit ab;
    int nidle;
    cyc = 0;
    while (cfg_ready !== 1'b1 && cyc < 20) begin
      @(negedge aclk);
      cyc++;
    end
    check("cmd_rdy", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_id    = id;
    cfg_len   = len;
    abort     = 1'($urandom);
    out_valid = 1'($urandom);
    out_ready = 1'($urandom);
    @(negedge aclk);
    cfg_valid = 1'b0;
    abort     = 1'b0;
    cnt       = 0;
    exp_err   = (id == 8'd0);
    if (id != 8'd0 && len != 16'd0) begin
      fin = 1'b0;
      cyc = 0;
      while (!fin && cyc < 400) begin
        check("run_kid", 32'(kernelID), 32'(id));
        check("run_busy", 32'(busy), 1);
        check("run_done", 32'(done), 0);
        check("run_rdy", 32'(cfg_ready), 0);
        check("run_cnt", 32'(tok_cnt), cnt);
        if (cyc < stall) begin
          out_valid = 1'b1;
          out_ready = 1'b0;
        end else begin
          out_valid = ($urandom_range(0, 99) < hs_pct);
          out_ready = ($urandom_range(0, 99) < 80);
        end
        ab = (abort_pct > 0) && ($urandom_range(0, 99) < abort_pct);
        if (abort_at >= 0 && cnt == abort_at) begin
          out_valid = 1'b1;
          out_ready = 1'b1;
          ab        = 1'b1;
        end
        abort     = ab;
        cfg_valid = 1'($urandom);
        cfg_id    = 8'($urandom);
        cfg_len   = 16'($urandom);
        hs = out_valid && out_ready;
        if (hs && cnt < 65535) cnt++;
        if (ab) begin
          fin     = 1'b1;
          exp_err = 1'b1;
        end else if (hs && cnt == int'(len)) begin
          fin     = 1'b1;
          exp_err = 1'b0;
        end
        @(negedge aclk);
        cyc++;
      end
      if (!fin) check("run_timeout", 0, 1);
      cfg_valid = 1'b0;
      abort     = 1'b0;
    end
    // Completion cycle.
    check("fin_done", 32'(done), 1);
    check("fin_err", 32'(err), 32'(exp_err));
    check("fin_kid", 32'(kernelID), 0);
    check("fin_busy", 32'(busy), 1);
    check("fin_rdy", 32'(cfg_ready), 0);
    check("fin_cnt", 32'(tok_cnt), cnt);
    out_valid = 1'($urandom);
    out_ready = 1'($urandom);
    abort     = 1'($urandom);
    @(negedge aclk);
    check("idle_done", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_rdy", 32'(cfg_ready), 1);
    check("idle_kid", 32'(kernelID), 0);
    check("idle_cnt", 32'(tok_cnt), cnt);
    // Traffic and abort in IDLE must leave everything alone.
    nidle = $urandom_range(0, 3);
    for (int k = 0; k < nidle; k++) begin
      out_valid = 1'($urandom);
      out_ready = 1'($urandom);
      abort     = 1'($urandom);
      @(negedge aclk);
      check("idle_hold_cnt", 32'(tok_cnt), cnt);
      check("idle_hold_rdy", 32'(cfg_ready), 1);
    end
    out_valid = 1'b0;
    out_ready = 1'b0;
    abort     = 1'b0;
  endtask

  logic [7:0]  rid;
  logic [15:0] rlen;

  initial begin
    total     = 0;
    bad       = 0;
    aresetn   = 1'b0;
    cfg_valid = 1'b0;
    cfg_id    = '0;
    cfg_len   = '0;
    abort     = 1'b0;
    out_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_kid", 32'(kernelID), 0);
    check("rst_rdy", 32'(cfg_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cnt", 32'(tok_cnt), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_rdy", 32'(cfg_ready), 1);

    // Normal run with gaps between tokens.
    run_cmd(8'd5, 16'd3, 50, 0, -1, 0);
    // The reserved ID completes at once with an error.
    run_cmd(8'd0, 16'd4, 50, 0, -1, 0);
    // A zero-length command completes at once with no error.
    run_cmd(8'd7, 16'd0, 50, 0, -1, 0);
    // Abort after 4 tokens, with a 5th token in the same cycle.
    run_cmd(8'd2, 16'd10, 60, 0, 4, 0);
    // A stalled sink for 20 cycles leaves the count and ID unchanged.
    run_cmd(8'd3, 16'd2, 100, 0, -1, 20);

    // Reset in the middle of a run.
    cfg_valid = 1'b1;
    cfg_id    = 8'd9;
    cfg_len   = 16'd10;
    @(negedge aclk);
    cfg_valid = 1'b0;
    check("mid_rst_kid_pre", 32'(kernelID), 9);
    repeat (3) @(negedge aclk);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_kid", 32'(kernelID), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    repeat (2) begin
      @(negedge aclk);
      check("mid_rst_nodone", 32'(done), 0);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    check("mid_rel_done", 32'(done), 0);
    check("mid_rel_rdy", 32'(cfg_ready), 1);
    check("mid_rel_busy", 32'(busy), 0);
    check("mid_rel_cnt", 32'(tok_cnt), 0);

    // Back-to-back: the held command is accepted again exactly 2 cycles after completion.
    cfg_valid = 1'b1;
    cfg_id    = 8'd4;
    cfg_len   = 16'd1;
    out_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge aclk);
    check("b2b_kid1", 32'(kernelID), 4);
    @(negedge aclk);
    check("b2b_done1", 32'(done), 1);
    check("b2b_err1", 32'(err), 0);
    check("b2b_rdy_low", 32'(cfg_ready), 0);
    @(negedge aclk);
    check("b2b_rdy", 32'(cfg_ready), 1);
    check("b2b_gap_kid", 32'(kernelID), 0);
    check("b2b_gap_done", 32'(done), 0);
    @(negedge aclk);
    check("b2b_kid2", 32'(kernelID), 4);
    check("b2b_busy2", 32'(busy), 1);
    cfg_valid = 1'b0;
    @(negedge aclk);
    check("b2b_done2", 32'(done), 1);
    check("b2b_cnt2", 32'(tok_cnt), 1);
    out_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge aclk);

    // Random commands.
    for (int n = 0; n < 30; n++) begin
      rid  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rlen = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      run_cmd(rid, rlen, int'($urandom_range(30, 100)), int'($urandom_range(0, 6)), -1,
              int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
